regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of all data buses.
REQ-002 Parameter MAXWAIT, default 4: consecutive denied cycles after which port B outranks port A (legal range 1-15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 a_req, b_req  input  1 each  access request from pipeline (A) / debug (B).
REQ-006 a_we, b_we  input  1 each  request includes a write.
REQ-007 a_raddr1, a_raddr2, b_raddr1, b_raddr2  input  5 each  read addresses.
REQ-008 a_waddr, b_waddr  input  5 each  write address.
REQ-009 a_wdata, b_wdata  input  DATAWIDTH each  write data.
REQ-010 a_gnt, b_gnt  output  1 each  request accepted this cycle.
REQ-011 a_rvalid, b_rvalid  output  1 each  read data valid for that port.
REQ-012 rdata1, rdata2  output  DATAWIDTH each  shared read data, qualified by a_rvalid/b_rvalid.
REQ-013 rf_readReg1, rf_readReg2, rf_writeReg  output  5 each  to register file.
REQ-014 rf_writeData  output  DATAWIDTH  to register file.
REQ-015 rf_write  output  1  register-file write enable.
REQ-016 rf_readData1, rf_readData2  input  DATAWIDTH each  register-file data, valid one cycle after address issue.

Function
REQ-017 At most one of a_gnt, b_gnt SHALL be high in any cycle; gnt SHALL be combinational from req and internal state, same cycle.
REQ-018 Priority: A wins when both request, unless wait_cnt == MAXWAIT, in which case B wins.
REQ-019 wait_cnt (4-bit) SHALL increment when b_req=1 and b_gnt=0, clear when b_gnt=1 or b_req=0, and saturate at MAXWAIT.
REQ-020 Granted port's raddr1/raddr2/waddr/wdata SHALL drive rf_* combinationally; with no grant, addresses SHALL be 0 and rf_write 0.
REQ-021 rf_write SHALL equal granted port's we AND (waddr != 0); writes to x0 SHALL be dropped while gnt still asserts.
REQ-022 Every grant is a read transaction: the granted port's rvalid SHALL assert exactly one cycle after gnt, for one cycle.
REQ-023 rdata1/rdata2 SHALL pass rf_readData1/rf_readData2 through unregistered; if the issue-cycle read address was 0, the corresponding rdata SHALL be forced to 0.
REQ-024 A registered owner flag (NONE/A/B) and two registered raddr-is-zero flags SHALL record the issue cycle for REQ-022/023.
REQ-025 Back-to-back grants to either port in consecutive cycles SHALL be supported at full throughput (one transaction per cycle).
REQ-026 Read of an address written in the same grant returns the new data (regfile write-through); arbiter SHALL NOT add bypass logic.
REQ-027 A request SHALL be held until granted; dropping req before gnt withdraws it with no side effect.

Reset
REQ-028 While rst_n=0 at a rising edge: wait_cnt=0, owner=NONE, zero flags=0; the next cycle a_rvalid=b_rvalid=0, rdata1=rdata2=0.
REQ-029 While rst_n=0, a_gnt=b_gnt=0 and rf_write=0 regardless of requests; a transaction issued the cycle before reset asserts SHALL NOT produce rvalid.

Verification
REQ-030 A only, a_we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5 -> a_gnt same cycle, rf_write=1, next cycle a_rvalid=1, rdata1=0xDEADBEEF.
REQ-031 A and B both held high, MAXWAIT=4 -> a_gnt cycles 0-3, b_gnt cycle 4, a_gnt cycle 5; wait_cnt 0 after cycle 4.
REQ-032 B alone, b_we=1, waddr=0, wdata=0x12345678, then read x0 -> b_gnt=1, rf_write=0, b_rvalid next cycle with rdata1=0.
REQ-033 Alternating A,B,A grants on consecutive cycles -> rvalid pattern a,b,a one cycle delayed, no gaps, no double-valid.
REQ-034 Grant to A, rst_n=0 next edge -> a_rvalid stays 0; outputs match REQ-028 values.
REQ-035 b_req pulsed 1 for 2 cycles under A contention then low 1 cycle, then high -> wait_cnt returns to 0 and B waits a full MAXWAIT again.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-port arbiter in front of a single-access register file: pipeline (A) has
// priority, debug (B) is promoted after MAXWAIT consecutive denied cycles.
module regfile_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int MAXWAIT   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_a_req,
    input  logic                 i_a_we,
    input  logic [4:0]           i_a_raddr1,
    input  logic [4:0]           i_a_raddr2,
    input  logic [4:0]           i_a_waddr,
    input  logic [DATAWIDTH-1:0] i_a_wdata,
    input  logic                 i_b_req,
    input  logic                 i_b_we,
    input  logic [4:0]           i_b_raddr1,
    input  logic [4:0]           i_b_raddr2,
    input  logic [4:0]           i_b_waddr,
    input  logic [DATAWIDTH-1:0] i_b_wdata,
    output logic                 o_a_gnt,
    output logic                 o_b_gnt,
    output logic                 o_a_rvalid,
    output logic                 o_b_rvalid,
    output logic [DATAWIDTH-1:0] o_rdata1,
    output logic [DATAWIDTH-1:0] o_rdata2,
    output logic [4:0]           o_rf_readReg1,
    output logic [4:0]           o_rf_readReg2,
    output logic [4:0]           o_rf_writeReg,
    output logic [DATAWIDTH-1:0] o_rf_writeData,
    output logic                 o_rf_write,
    input  logic [DATAWIDTH-1:0] i_rf_readData1,
    input  logic [DATAWIDTH-1:0] i_rf_readData2
);

    localparam logic [3:0] W_MAX = 4'(MAXWAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    owner_t         r_owner;
    logic [3:0]     r_wait_cnt;
    logic           r_z1;
    logic           r_z2;

    logic                 w_b_pri;
    logic                 w_a_gnt;
    logic                 w_b_gnt;
    logic                 w_we;
    logic [4:0]           w_raddr1;
    logic [4:0]           w_raddr2;
    logic [4:0]           w_waddr;
    logic [DATAWIDTH-1:0] w_wdata;
    logic                 w_live;

    // B outranks A only once it has been starved for the full MAXWAIT window.
    assign w_b_pri = (r_wait_cnt == W_MAX);
    assign w_a_gnt = i_rst_n && i_a_req && !(i_b_req && w_b_pri);
    assign w_b_gnt = i_rst_n && i_b_req && (!i_a_req || w_b_pri);

    always_comb begin
        w_we     = 1'b0;
        w_raddr1 = '0;
        w_raddr2 = '0;
        w_waddr  = '0;
        w_wdata  = '0;
        if (w_a_gnt) begin
            w_we     = i_a_we;
            w_raddr1 = i_a_raddr1;
            w_raddr2 = i_a_raddr2;
            w_waddr  = i_a_waddr;
            w_wdata  = i_a_wdata;
        end else if (w_b_gnt) begin
            w_we     = i_b_we;
            w_raddr1 = i_b_raddr1;
            w_raddr2 = i_b_raddr2;
            w_waddr  = i_b_waddr;
            w_wdata  = i_b_wdata;
        end
    end

    assign o_a_gnt        = w_a_gnt;
    assign o_b_gnt        = w_b_gnt;
    assign o_rf_readReg1  = w_raddr1;
    assign o_rf_readReg2  = w_raddr2;
    assign o_rf_writeReg  = w_waddr;
    assign o_rf_writeData = w_wdata;
    // x0 is hardwired: the grant still completes as a read, the write is dropped.
    assign o_rf_write     = w_we && (w_waddr != 5'd0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
            r_owner    <= OWN_NONE;
            r_z1       <= 1'b0;
            r_z2       <= 1'b0;
        end else begin
            if (i_b_req && !w_b_gnt)
                r_wait_cnt <= w_b_pri ? r_wait_cnt : r_wait_cnt + 4'd1;
            else
                r_wait_cnt <= '0;

            if (w_a_gnt)      r_owner <= OWN_A;
            else if (w_b_gnt) r_owner <= OWN_B;
            else              r_owner <= OWN_NONE;

            r_z1 <= (w_a_gnt || w_b_gnt) && (w_raddr1 == 5'd0);
            r_z2 <= (w_a_gnt || w_b_gnt) && (w_raddr2 == 5'd0);
        end
    end

    // Gating with reset kills a response whose issue cycle preceded reset assertion.
    assign w_live     = i_rst_n && (r_owner != OWN_NONE);
    assign o_a_rvalid = i_rst_n && (r_owner == OWN_A);
    assign o_b_rvalid = i_rst_n && (r_owner == OWN_B);
    assign o_rdata1   = (w_live && !r_z1) ? i_rf_readData1 : '0;
    assign o_rdata2   = (w_live && !r_z2) ? i_rf_readData2 : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a write-through register-file model.
module tb_regfile_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [4:0]    a_raddr1, a_raddr2, a_waddr, b_raddr1, b_raddr2, b_waddr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, rf_write;
    logic [DW-1:0] rdata1, rdata2, rf_writeData, rf_rd1, rf_rd2;
    logic [4:0]    rf_ra1, rf_ra2, rf_wa;

    logic [DW-1:0] regs [32];
    logic          init = 1'b1;
    int            n_tests = 0;
    int            n_fail  = 0;

    regfile_arbiter #(.DATAWIDTH(DW), .MAXWAIT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_raddr1(a_raddr1), .i_a_raddr2(a_raddr2),
        .i_a_waddr(a_waddr), .i_a_wdata(a_wdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_raddr1(b_raddr1), .i_b_raddr2(b_raddr2),
        .i_b_waddr(b_waddr), .i_b_wdata(b_wdata),
        .o_a_gnt(a_gnt), .o_b_gnt(b_gnt), .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
        .o_rdata1(rdata1), .o_rdata2(rdata2),
        .o_rf_readReg1(rf_ra1), .o_rf_readReg2(rf_ra2), .o_rf_writeReg(rf_wa),
        .o_rf_writeData(rf_writeData), .o_rf_write(rf_write),
        .i_rf_readData1(rf_rd1), .i_rf_readData2(rf_rd2)
    );

    always #5 clk = ~clk;

    // Register file: registered reads, same-edge write visible on read (write-through).
    // x0 holds junk so the arbiter's zero forcing is observable.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i);
            regs[0] <= 32'hBAD0_BAD0;
        end else begin
            if (rf_write) regs[rf_wa] <= rf_writeData;
            rf_rd1 <= (rf_write && rf_wa == rf_ra1) ? rf_writeData : regs[rf_ra1];
            rf_rd2 <= (rf_write && rf_wa == rf_ra2) ? rf_writeData : regs[rf_ra2];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_raddr1 = 0; a_raddr2 = 0; a_waddr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_raddr1 = 0; b_raddr2 = 0; b_waddr = 0; b_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle();
        a_req = 1; a_we = 1; a_waddr = 5'd3; a_wdata = 32'h55;
        #2;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_rf_write", rf_write, 0);
        tick();
        init = 1'b0;
        tick();
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_rdata2", rdata2, 0);
        chk("rst_wait", dut.r_wait_cnt, 0);
        rst_n = 1;
        idle();
        #1;
        chk("idle_gnt", {a_gnt, b_gnt}, 0);
        chk("idle_ra1", rf_ra1, 0);
        tick();

        // Write then read the same register in one grant.
        a_req = 1; a_we = 1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF; a_raddr1 = 5'd5;
        #1;
        chk("wr_a_gnt", a_gnt, 1);
        chk("wr_b_gnt", b_gnt, 0);
        chk("wr_rf_write", rf_write, 1);
        chk("wr_rf_wa", rf_wa, 5);
        chk("wr_rf_ra1", rf_ra1, 5);
        tick();
        chk("wr_a_rvalid", a_rvalid, 1);
        chk("wr_b_rvalid", b_rvalid, 0);
        chk("wr_rdata1", rdata1, 32'hDEADBEEF);
        chk("wr_rdata2_x0", rdata2, 0);
        idle();
        #1;
        chk("wr_idle_write", rf_write, 0);
        tick();
        chk("wr_rvalid_once", a_rvalid, 0);

        // B writes x0: dropped, still granted; read x0 returns 0.
        b_req = 1; b_we = 1; b_waddr = 5'd0; b_wdata = 32'h12345678;
        b_raddr1 = 5'd0; b_raddr2 = 5'd5;
        #1;
        chk("x0_b_gnt", b_gnt, 1);
        chk("x0_a_gnt", a_gnt, 0);
        chk("x0_rf_write", rf_write, 0);
        tick();
        chk("x0_b_rvalid", b_rvalid, 1);
        chk("x0_a_rvalid", a_rvalid, 0);
        chk("x0_rdata1", rdata1, 0);
        chk("x0_rdata2", rdata2, 32'hDEADBEEF);
        idle();
        tick();

        // Contention: A wins 4 cycles, then B, then A again.
        a_req = 1; b_req = 1; a_raddr1 = 5'd1; b_raddr1 = 5'd2;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("ct%0d_a_gnt", c), a_gnt, (c != 4));
            chk($sformatf("ct%0d_b_gnt", c), b_gnt, (c == 4));
            tick();
            chk($sformatf("ct%0d_a_rvalid", c), a_rvalid, (c != 4));
            chk($sformatf("ct%0d_b_rvalid", c), b_rvalid, (c == 4));
            chk($sformatf("ct%0d_rdata1", c), rdata1, (c == 4) ? 32'h1000_0002 : 32'h1000_0001);
            if (c == 4) chk("ct_wait_clr", dut.r_wait_cnt, 0);
        end

        // B pulses, drops for one cycle: starvation count restarts.
        idle();
        tick();
        a_req = 1; b_req = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("pl%0d_b_gnt", k), b_gnt, 0);
            tick();
        end
        chk("pl_wait2", dut.r_wait_cnt, 2);
        b_req = 0;
        #1;
        chk("pl_drop_a_gnt", a_gnt, 1);
        tick();
        chk("pl_wait0", dut.r_wait_cnt, 0);
        b_req = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rw%0d_b_gnt", k), b_gnt, (k == 4));
            chk($sformatf("rw%0d_a_gnt", k), a_gnt, (k != 4));
            tick();
        end

        // Alternating A,B,A at full throughput.
        idle();
        tick();
        a_req = 1; a_raddr1 = 5'd5;
        #1;
        chk("alt0_a_gnt", a_gnt, 1);
        tick();
        chk("alt0_rv", {a_rvalid, b_rvalid}, 2'b10);
        chk("alt0_rdata1", rdata1, 32'hDEADBEEF);
        a_req = 0; b_req = 1; b_raddr1 = 5'd3;
        #1;
        chk("alt1_b_gnt", b_gnt, 1);
        tick();
        chk("alt1_rv", {a_rvalid, b_rvalid}, 2'b01);
        chk("alt1_rdata1", rdata1, 32'h1000_0003);
        b_req = 0; a_req = 1;
        #1;
        chk("alt2_a_gnt", a_gnt, 1);
        tick();
        chk("alt2_rv", {a_rvalid, b_rvalid}, 2'b10);
        idle();
        tick();
        chk("alt3_rv", {a_rvalid, b_rvalid}, 2'b00);
        chk("alt3_rdata1", rdata1, 0);

        // Grant to A, then reset asserts before the response cycle.
        a_req = 1; a_raddr1 = 5'd5; a_we = 1; a_waddr = 5'd7; a_wdata = 32'h77;
        #1;
        chk("rr_a_gnt", a_gnt, 1);
        tick();
        rst_n = 0;
        #1;
        chk("rr_a_rvalid_kill", a_rvalid, 0);
        chk("rr_gnt_in_rst", a_gnt, 0);
        chk("rr_write_in_rst", rf_write, 0);
        tick();
        chk("rr_a_rvalid", a_rvalid, 0);
        chk("rr_b_rvalid", b_rvalid, 0);
        chk("rr_rdata1", rdata1, 0);
        chk("rr_rdata2", rdata2, 0);
        idle();
        rst_n = 1;
        tick();
        chk("rr_post_rv", {a_rvalid, b_rvalid}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
